// File: rtl/fp_pkg.sv
// Shared floating-point operand definitions for the encode arbiter and its testbench.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_RES_W  = 32;

    typedef struct packed {
        logic                 mode_fp;   // 0 = half, 1 = single
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp_operand_t;

endpackage

// File: rtl/fp_encode_arbiter_if.sv
// Requester and result handshake bundle for fp_encode_arbiter.
interface fp_encode_arbiter_if #(
    parameter int TAG_W = 4
);
    import fp_pkg::*;

    logic                 req0_valid;
    logic                 req0_ready;
    logic                 req0_mode_fp;
    logic                 req0_sign;
    logic [FP_EXP_W-1:0]  req0_exp;
    logic [FP_MANT_W-1:0] req0_mant;
    logic [TAG_W-1:0]     req0_tag;

    logic                 req1_valid;
    logic                 req1_ready;
    logic                 req1_mode_fp;
    logic                 req1_sign;
    logic [FP_EXP_W-1:0]  req1_exp;
    logic [FP_MANT_W-1:0] req1_mant;
    logic [TAG_W-1:0]     req1_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [FP_RES_W-1:0]  out_result;
    logic                 out_src;
    logic [TAG_W-1:0]     out_tag;

    // Requester/result-sink side
    modport master (
        output req0_valid, req0_mode_fp, req0_sign, req0_exp, req0_mant, req0_tag,
        output req1_valid, req1_mode_fp, req1_sign, req1_exp, req1_mant, req1_tag,
        input  req0_ready, req1_ready,
        input  out_valid, out_result, out_src, out_tag,
        output out_ready
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_mode_fp, req0_sign, req0_exp, req0_mant, req0_tag,
        input  req1_valid, req1_mode_fp, req1_sign, req1_exp, req1_mant, req1_tag,
        output req0_ready, req1_ready,
        output out_valid, out_result, out_src, out_tag,
        input  out_ready
    );

endinterface

// File: rtl/fp_encode_arbiter_rr_arb2.sv
// Two-input round-robin picker: one-hot grant from valids and the last-granted index.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/fp_encode_arbiter.sv
// Two-requester arbiter feeding a shared FP encoder through a two-stage pipeline.
// Define FP_ENCODE_ARB_STATS_EN to add saturating per-requester grant counters.
module fp_encode_arbiter
    import fp_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_mode_fp,
    input  logic                 req0_sign,
    input  logic [FP_EXP_W-1:0]  req0_exp,
    input  logic [FP_MANT_W-1:0] req0_mant,
    input  logic [TAG_W-1:0]     req0_tag,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_mode_fp,
    input  logic                 req1_sign,
    input  logic [FP_EXP_W-1:0]  req1_exp,
    input  logic [FP_MANT_W-1:0] req1_mant,
    input  logic [TAG_W-1:0]     req1_tag,

    output logic                 enc_mode_fp,
    output logic                 enc_sign,
    output logic [FP_EXP_W-1:0]  enc_exp,
    output logic [FP_MANT_W-1:0] enc_mant,
    input  logic [FP_RES_W-1:0]  enc_result,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FP_RES_W-1:0]  out_result,
    output logic                 out_src,
    output logic [TAG_W-1:0]     out_tag
`ifdef FP_ENCODE_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]     grant_cnt0,
    output logic [CNT_W-1:0]     grant_cnt1
`endif
);

    // A non-positive counter width cannot be built; nothing is generated for it.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    fp_operand_t      req_op [2];
    logic [TAG_W-1:0] req_tag [2];
    logic [1:0]       req_valid;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_op[0]  = '{mode_fp: req0_mode_fp, sign: req0_sign, exp: req0_exp, mant: req0_mant};
    assign req_op[1]  = '{mode_fp: req1_mode_fp, sign: req1_sign, exp: req1_exp, mant: req1_mant};
    assign req_tag[0] = req0_tag;
    assign req_tag[1] = req1_tag;

    logic                a_valid_q, a_valid_d;
    fp_operand_t         a_op_q,    a_op_d;
    logic                a_src_q,   a_src_d;
    logic [TAG_W-1:0]    a_tag_q,   a_tag_d;
    logic                b_valid_q, b_valid_d;
    logic [FP_RES_W-1:0] b_result_q, b_result_d;
    logic                b_src_q,   b_src_d;
    logic [TAG_W-1:0]    b_tag_q,   b_tag_d;
    logic                last_q,    last_d;

    logic [1:0] grant;
    logic       move_ab;
    logic       a_free;
    logic       accept;
    logic       acc_src;

    rr_arb2 u_rr_arb2 (
        .valid_i (req_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    assign move_ab = a_valid_q && (!b_valid_q || out_ready);
    assign a_free  = !a_valid_q || move_ab;
    assign accept  = (|grant) && a_free && !rst;
    assign acc_src = grant[1];

    assign req0_ready = grant[0] && a_free && !rst;
    assign req1_ready = grant[1] && a_free && !rst;

    always_comb begin
        a_valid_d  = a_valid_q;
        a_op_d     = a_op_q;
        a_src_d    = a_src_q;
        a_tag_d    = a_tag_q;
        b_valid_d  = b_valid_q;
        b_result_d = b_result_q;
        b_src_d    = b_src_q;
        b_tag_d    = b_tag_q;
        last_d     = last_q;

        if (accept) begin
            a_valid_d = 1'b1;
            a_op_d    = req_op[acc_src];
            a_src_d   = acc_src;
            a_tag_d   = req_tag[acc_src];
            last_d    = acc_src;
        end else if (move_ab) begin
            a_valid_d = 1'b0;
        end

        // B keeps its payload after a handoff so the outputs never glitch.
        if (move_ab) begin
            b_valid_d  = 1'b1;
            b_result_d = enc_result;
            b_src_d    = a_src_q;
            b_tag_d    = a_tag_q;
        end else if (out_ready) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q  <= 1'b0;
            a_op_q     <= '0;
            a_src_q    <= 1'b0;
            a_tag_q    <= '0;
            b_valid_q  <= 1'b0;
            b_result_q <= '0;
            b_src_q    <= 1'b0;
            b_tag_q    <= '0;
            last_q     <= 1'b1;
        end else begin
            a_valid_q  <= a_valid_d;
            a_op_q     <= a_op_d;
            a_src_q    <= a_src_d;
            a_tag_q    <= a_tag_d;
            b_valid_q  <= b_valid_d;
            b_result_q <= b_result_d;
            b_src_q    <= b_src_d;
            b_tag_q    <= b_tag_d;
            last_q     <= last_d;
        end
    end

    fp_operand_t enc_op;
    assign enc_op      = a_valid_q ? a_op_q : '0;
    assign enc_mode_fp = enc_op.mode_fp;
    assign enc_sign    = enc_op.sign;
    assign enc_exp     = enc_op.exp;
    assign enc_mant    = enc_op.mant;

    assign out_valid  = b_valid_q;
    assign out_result = b_result_q;
    assign out_src    = b_src_q;
    assign out_tag    = b_tag_q;

`ifdef FP_ENCODE_ARB_STATS_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_stats
        logic [CNT_W-1:0] cnt_q;
        logic             hit;

        assign hit = accept && (acc_src == 1'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (hit && !(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign grant_cnt0 = g_stats[0].cnt_q;
    assign grant_cnt1 = g_stats[1].cnt_q;
`endif

endmodule

// File: tb/tb_fp_encode_arbiter.sv
// Scoreboard bench for fp_encode_arbiter with a half/single encoder model on enc_*.
// Build with FP_ENCODE_ARB_STATS_EN to also exercise the grant counters (CNT_W=2).
module tb_fp_encode_arbiter;
    import fp_pkg::*;

    localparam int TAG_W = 4;
`ifdef FP_ENCODE_ARB_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_encode_arbiter_if #(.TAG_W(TAG_W)) bus ();

    logic                 enc_mode_fp;
    logic                 enc_sign;
    logic [FP_EXP_W-1:0]  enc_exp;
    logic [FP_MANT_W-1:0] enc_mant;
    logic [FP_RES_W-1:0]  enc_result;
`ifdef FP_ENCODE_ARB_STATS_EN
    logic [CNT_W-1:0]     grant_cnt0;
    logic [CNT_W-1:0]     grant_cnt1;
`endif

    fp_encode_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (bus.req0_valid),
        .req0_ready   (bus.req0_ready),
        .req0_mode_fp (bus.req0_mode_fp),
        .req0_sign    (bus.req0_sign),
        .req0_exp     (bus.req0_exp),
        .req0_mant    (bus.req0_mant),
        .req0_tag     (bus.req0_tag),
        .req1_valid   (bus.req1_valid),
        .req1_ready   (bus.req1_ready),
        .req1_mode_fp (bus.req1_mode_fp),
        .req1_sign    (bus.req1_sign),
        .req1_exp     (bus.req1_exp),
        .req1_mant    (bus.req1_mant),
        .req1_tag     (bus.req1_tag),
        .enc_mode_fp  (enc_mode_fp),
        .enc_sign     (enc_sign),
        .enc_exp      (enc_exp),
        .enc_mant     (enc_mant),
        .enc_result   (enc_result),
        .out_valid    (bus.out_valid),
        .out_ready    (bus.out_ready),
        .out_result   (bus.out_result),
        .out_src      (bus.out_src),
        .out_tag      (bus.out_tag)
`ifdef FP_ENCODE_ARB_STATS_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1)
`endif
    );

    // Shared encoder: single passes through, half rebiases and truncates the mantissa.
    function automatic logic [31:0] enc_model(input logic mode, input logic s,
                                              input logic [7:0] e, input logic [22:0] m);
        logic [7:0] he;
        he = e - 8'd112;
        if (mode)        return {s, e, m};
        if (e == 8'hFF)  return {16'h0, s, 5'h1F, m[22:13]};
        if (e > 8'd142)  return {16'h0, s, 5'h1F, 10'h0};
        if (e < 8'd113)  return {16'h0, s, 15'h0};
        return {16'h0, s, he[4:0], m[22:13]};
    endfunction

    assign enc_result = enc_model(enc_mode_fp, enc_sign, enc_exp, enc_mant);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]      result;
        logic             src;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    exp_t mon_e;
    int   acc_total = 0;
    logic acc0 = 1'b0;
    logic acc1 = 1'b0;
    int   pend0 = 0;
    int   pend1 = 0;

    // Acceptances become expectations; completed outputs are popped and compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_valid && bus.req0_ready && bus.req1_valid && bus.req1_ready)
                check_val("one_accept", 1, 0);
            if (bus.req0_valid && bus.req0_ready) begin
                exp_q.push_back('{enc_model(bus.req0_mode_fp, bus.req0_sign, bus.req0_exp,
                                            bus.req0_mant), 1'b0, bus.req0_tag});
                grant_log.push_back(0);
                acc0 = 1'b1;
                acc_total++;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                exp_q.push_back('{enc_model(bus.req1_mode_fp, bus.req1_sign, bus.req1_exp,
                                            bus.req1_mant), 1'b1, bus.req1_tag});
                grant_log.push_back(1);
                acc1 = 1'b1;
                acc_total++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_out", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("out: result=0x%08h src=%0d tag=%0d", bus.out_result, bus.out_src, bus.out_tag);
                    check_val("out_result", bus.out_result, mon_e.result);
                    check_val("out_src", bus.out_src, mon_e.src);
                    check_val("out_tag", bus.out_tag, mon_e.tag);
                end
            end
        end
    end

    task automatic new_payload(input int n);
        if (n == 0) begin
            bus.req0_mode_fp = 1'($urandom_range(0, 1));
            bus.req0_sign    = 1'($urandom_range(0, 1));
            bus.req0_exp     = 8'($urandom);
            bus.req0_mant    = 23'($urandom);
            bus.req0_tag     = TAG_W'($urandom);
        end else begin
            bus.req1_mode_fp = 1'($urandom_range(0, 1));
            bus.req1_sign    = 1'($urandom_range(0, 1));
            bus.req1_exp     = 8'($urandom);
            bus.req1_mant    = 23'($urandom);
            bus.req1_tag     = TAG_W'($urandom);
        end
    endtask

    task automatic set_pend(input int n, input int count);
        new_payload(n);
        if (n == 0) begin pend0 = count; bus.req0_valid = (count > 0); end
        else        begin pend1 = count; bus.req1_valid = (count > 0); end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (acc0) begin acc0 = 1'b0; pend0--; new_payload(0); end
        if (acc1) begin acc1 = 1'b0; pend1--; new_payload(1); end
        bus.req0_valid = (pend0 > 0);
        bus.req1_valid = (pend1 > 0);
    endtask

    task automatic run_idle(input int max_cycles);
        int k;
        k = 0;
        while ((pend0 > 0 || pend1 > 0 || exp_q.size() != 0) && k < max_cycles) begin
            step();
            k++;
        end
        check_val("drain_busy", (pend0 > 0 || pend1 > 0 || exp_q.size() != 0), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend0 = 0;
        pend1 = 0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   mark;
        int   a0;
        logic have_ref;
        logic [63:0] ref_out;
        logic [63:0] ref_enc;

        rst = 1'b1;
        bus.out_ready = 1'b1;
        set_pend(0, 0);
        set_pend(1, 0);
        bus.req0_valid = 1'b1;

        // Reset state, with a requester already valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready0", bus.req0_ready, 0);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_result", bus.out_result, 0);
        check_val("rst_enc_exp", enc_exp, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req0_valid = 1'b0;

        // Single-precision request and its two-cycle latency
        pend0 = 1;
        bus.req0_valid = 1'b1; bus.req0_mode_fp = 1'b1; bus.req0_sign = 1'b0;
        bus.req0_exp = 8'h7F;  bus.req0_mant = 23'h0;    bus.req0_tag = 4'd3;
        step();
        check_val("lat_edge_n", bus.out_valid, 0);
        step();
        check_val("lat_edge_n1", bus.out_valid, 1);
        check_val("single_result", bus.out_result, 32'h3F80_0000);
        check_val("single_src", bus.out_src, 0);
        check_val("single_tag", bus.out_tag, 3);
        run_idle(10);

        // Half-precision request from requester 1
        pend1 = 1;
        bus.req1_valid = 1'b1; bus.req1_mode_fp = 1'b0; bus.req1_sign = 1'b1;
        bus.req1_exp = 8'h7F;  bus.req1_mant = 23'h0;    bus.req1_tag = 4'd5;
        step();
        step();
        check_val("half_result", bus.out_result, 32'h0000_BC00);
        check_val("half_src", bus.out_src, 1);
        run_idle(10);

        // Contention after reset: 0,1,0,1
        do_reset();
        mark = grant_log.size();
        set_pend(0, 2);
        set_pend(1, 2);
        run_idle(40);
        check_val("cont_count", grant_log.size() - mark, 4);
        for (int i = 0; i < 4 && mark + i < grant_log.size(); i++)
            check_val($sformatf("cont_grant%0d", i), grant_log[mark + i], i % 2);
`ifdef FP_ENCODE_ARB_STATS_EN
        check_val("cont_cnt0", grant_cnt0, 2);
        check_val("cont_cnt1", grant_cnt1, 2);
`endif

        // Back-to-back acceptance with the sink always ready
        a0 = acc_total;
        set_pend(0, 6);
        repeat (6) step();
        check_val("throughput", acc_total - a0, 6);
        run_idle(20);

        // Backpressure: 5 stalled cycles, 3 requests pending
        bus.out_ready = 1'b0;
        a0 = acc_total;
        have_ref = 1'b0;
        ref_out = '0;
        ref_enc = '0;
        set_pend(0, 3);
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 2) ref_enc = {enc_mode_fp, enc_sign, enc_exp, enc_mant};
            if (bus.out_valid) begin
                if (!have_ref) begin
                    ref_out = {bus.out_result, bus.out_src, bus.out_tag};
                    have_ref = 1'b1;
                end else begin
                    check_val("bp_out_hold", {bus.out_result, bus.out_src, bus.out_tag}, ref_out);
                end
            end
        end
        #1;
        check_val("bp_accepts", acc_total - a0, 2);
        check_val("bp_ready0", bus.req0_ready, 0);
        check_val("bp_enc_hold", {enc_mode_fp, enc_sign, enc_exp, enc_mant}, ref_enc);
        bus.out_ready = 1'b1;
        run_idle(30);
        check_val("bp_total", acc_total - a0, 3);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        set_pend(0, 2);
        repeat (3) step();
        check_val("mid_full", bus.out_valid, 1);
        rst = 1'b1;
        pend0 = 0;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        check_val("mid_rst_ready", bus.req0_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.out_ready = 1'b1;
        exp_q.delete();
        acc0 = 1'b0;
        acc1 = 1'b0;
        check_val("mid_out_valid", bus.out_valid, 0);
        check_val("mid_out_result", bus.out_result, 0);
        mark = grant_log.size();
        set_pend(0, 1);
        set_pend(1, 1);
        run_idle(20);
        check_val("mid_cont_count", grant_log.size() - mark, 2);
        if (grant_log.size() > mark)
            check_val("mid_first_grant", grant_log[mark], 0);

`ifdef FP_ENCODE_ARB_STATS_EN
        // Saturation of a 2-bit counter
        do_reset();
        set_pend(0, 5);
        run_idle(30);
        check_val("sat_cnt0", grant_cnt0, 3);
        check_val("sat_cnt1", grant_cnt1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
